fs_accel_quant_requant: RTL and testbench

- Sequential consumer of the quantization multiple table: requantizes one signed 32-bit accumulator to a saturated int8 activation.
- Nibble-serial multiply, MSB nibble first: each cycle selects k*quant_muler (k = nibble value, 0..15) and shift-adds it.
- Then a rounding right shift, sign restore, zero-point add and clamp.
- Sits between the conv/FC accumulator stage and the output activation buffer; valid/ready on both sides.

---
 rtl/fs_accel_quant_requant.sv | 181 ++++++++++++++++++
 tb/tb_fs_accel_quant_requant.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_accel_quant_requant.sv
`default_nettype none
// ============================================================================
//  Module   : fs_accel_quant_requant
//  Function : Requantizes one signed accumulator to a saturated signed
//             activation. The magnitude is multiplied by quant_muler one
//             nibble per cycle, MSB nibble first. A rounding right shift
//             follows, then the sign is restored, the zero point is added
//             and the result is clamped.
//  Options  : FS_ACCEL_QUANT_RELU_EN adds a relu_en_i port. When it is set,
//             the lower clamp bound is raised to the zero point, which gives
//             a fused ReLU.
//  Revision : 1.0 - initial release
// ============================================================================
module fs_accel_quant_requant #(
   parameter int ACC_W = 32,
   parameter int MUL_W = 32,
   parameter int OUT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [ACC_W-1:0] acc_in_i,
   input  logic [MUL_W-1:0] quant_muler_i,
   input  logic [5:0]       quant_shift_i,
   input  logic [OUT_W-1:0] out_zp_i,
`ifdef FS_ACCEL_QUANT_RELU_EN
   input  logic             relu_en_i,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_data_o
);

   localparam int NIB   = ACC_W / 4;
   localparam int P_W   = ACC_W + MUL_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   // Signed working width: +-2^OUT_W plus the zero point, with headroom.
   localparam int V_W   = OUT_W + 3;

   localparam logic [P_W:0]           R_CAP_P = (P_W+1)'(2**OUT_W);
   localparam logic [OUT_W:0]         R_CAP   = (OUT_W+1)'(2**OUT_W);
   localparam logic signed [V_W-1:0]  V_HI    = V_W'((2**(OUT_W-1)) - 1);
   localparam logic signed [V_W-1:0]  V_LO    = V_W'(-(2**(OUT_W-1)));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sign_q;
   logic [ACC_W-1:0] mag_q;
   logic [MUL_W-1:0] mul_q;
   logic [5:0]       shift_q;
   logic [OUT_W-1:0] zp_q;
   logic [P_W-1:0]   prod_q;
   logic [OUT_W-1:0] out_data_q;
   logic             out_valid_q;
   logic             in_ready_q;
`ifdef FS_ACCEL_QUANT_RELU_EN
   logic             relu_q;
`endif

   // mag_q is shifted left every step, so the active nibble is always on top.
   logic [3:0]     nib_w;
   logic [P_W-1:0] prod_d;
   assign nib_w  = mag_q[ACC_W-1 -: 4];
   assign prod_d = (prod_q << 4)
                 + ({{(P_W-4){1'b0}}, nib_w} * {{ACC_W{1'b0}}, mul_q});

   // Rounding shift on the magnitude, one extra bit so the bias cannot wrap.
   logic [P_W:0]   bias_w;
   logic [P_W:0]   sum_w;
   logic [P_W:0]   shr_w;
   logic [OUT_W:0] r_w;
   assign bias_w = (shift_q == 6'd0) ? '0
                 : ({{P_W{1'b0}}, 1'b1} << (shift_q - 6'd1));
   assign sum_w  = {1'b0, prod_q} + bias_w;
   assign shr_w  = sum_w >> shift_q;
   assign r_w    = (shr_w > R_CAP_P) ? R_CAP : shr_w[OUT_W:0];

   // Sign restore and zero-point add in a width that cannot overflow.
   logic signed [V_W-1:0] rs_w;
   logic signed [V_W-1:0] zp_ext_w;
   logic signed [V_W-1:0] v_w;
   logic signed [V_W-1:0] lo_w;
   assign rs_w     = $signed({2'b00, r_w});
   assign zp_ext_w = $signed({{3{zp_q[OUT_W-1]}}, zp_q});
   assign v_w      = (sign_q ? -rs_w : rs_w) + zp_ext_w;
`ifdef FS_ACCEL_QUANT_RELU_EN
   // The zero point never lies below the int range, so max(zp, LO) is zp.
   assign lo_w     = relu_q ? zp_ext_w : V_LO;
`else
   assign lo_w     = V_LO;
`endif

   // Clamp the signed value into the output range.
   logic [OUT_W-1:0] sat_w;
   always_comb begin
      sat_w = v_w[OUT_W-1:0];
      if (v_w > V_HI) begin
         sat_w = V_HI[OUT_W-1:0];
      end else if (v_w < lo_w) begin
         sat_w = lo_w[OUT_W-1:0];
      end
   end

   // Control FSM: accept operands, run NIB multiply steps, round, then hand off.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         mul_q       <= '0;
         shift_q     <= '0;
         zp_q        <= '0;
         prod_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef FS_ACCEL_QUANT_RELU_EN
         relu_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  sign_q     <= acc_in_i[ACC_W-1];
                  // Negating the most negative value yields 2^(ACC_W-1) unsigned.
                  mag_q      <= acc_in_i[ACC_W-1] ? -acc_in_i : acc_in_i;
                  mul_q      <= quant_muler_i;
                  shift_q    <= quant_shift_i;
                  zp_q       <= out_zp_i;
`ifdef FS_ACCEL_QUANT_RELU_EN
                  relu_q     <= relu_en_i;
`endif
                  prod_q     <= '0;
                  cnt_q      <= CNT_W'(NIB - 1);
                  in_ready_q <= 1'b0;
                  state_q    <= MUL;
               end
            end
            MUL: begin
               prod_q <= prod_d;
               mag_q  <= mag_q << 4;
               cnt_q  <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               out_data_q  <= sat_w;
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fs_accel_quant_requant.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fs_accel_quant_requant
//  Function : Self-checking bench for fs_accel_quant_requant. It applies a
//             table of vectors and uses a scoreboard with latency, hold and
//             reset-abort sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fs_accel_quant_requant;

   typedef struct {
      logic [31:0] acc;
      logic [31:0] mul;
      logic [5:0]  sh;
      logic [7:0]  zp;
      logic        relu;
      logic [7:0]  want;
   } vec_t;

   typedef struct {
      logic [7:0] want;
      int         cyc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] acc_in = '0;
   logic [31:0] quant_muler = '0;
   logic [5:0]  quant_shift = '0;
   logic [7:0]  out_zp = '0;
   logic        relu = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   hs_edge = 0;
   sb_t  sb[$];
   vec_t vecs[$];

   fs_accel_quant_requant #(.ACC_W(32), .MUL_W(32), .OUT_W(8)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .acc_in_i      (acc_in),
      .quant_muler_i (quant_muler),
      .quant_shift_i (quant_shift),
      .out_zp_i      (out_zp),
`ifdef FS_ACCEL_QUANT_RELU_EN
      .relu_en_i     (relu),
`endif
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_data_o    (out_data)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Output monitor: handshake data, latency, hold stability, busy in_ready.
   logic       hold_q = 1'b0;
   logic [7:0] hold_data = '0;
   logic       prev_v = 1'b0;
   sb_t        s;
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (sb.size() > 0) check("in_ready_busy", {63'd0, in_ready}, 64'd0);
         if (hold_q) begin
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_data", {56'd0, out_data}, {56'd0, hold_data});
         end
         if (out_valid && !prev_v && sb.size() > 0)
            check("latency", 64'(cyc - sb[0].cyc), 64'd9);
         if (out_valid && out_ready) begin
            if (sb.size() > 0) begin
               s = sb.pop_front();
               check("out_data", {56'd0, out_data}, {56'd0, s.want});
            end else begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got data %0h want no output", out_data);
            end
            hs_edge = cyc + 1;
         end
         hold_q    = out_valid && !out_ready;
         hold_data = out_data;
         prev_v    = out_valid;
      end else begin
         hold_q = 1'b0;
         prev_v = 1'b0;
      end
   end

   task automatic send(input vec_t v, output int acc_cyc);
      bit ok = 1'b0;
      acc_in      = v.acc;
      quant_muler = v.mul;
      quant_shift = v.sh;
      out_zp      = v.zp;
      relu        = v.relu;
      in_valid    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble operands while busy; they must be ignored.
      acc_in      = $urandom;
      quant_muler = $urandom;
      quant_shift = 6'($urandom);
      out_zp      = 8'($urandom);
      relu        = 1'($urandom);
      if (ok) begin
         acc_cyc = cyc;
         sb.push_back('{want: v.want, cyc: cyc});
      end else begin
         acc_cyc = -1;
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 want 1");
      end
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want test completion");
      $fatal(1);
   end

   initial begin
      int   ac;
      bit   ok;
      vec_t va;
      vec_t vb;

      vecs.push_back('{acc: 32'd100,        mul: 32'h40000000, sh: 6'd31, zp: 8'h00, relu: 1'b0, want: 8'h32});
      vecs.push_back('{acc: 32'hFFFFFFFD,   mul: 32'h40000000, sh: 6'd31, zp: 8'h00, relu: 1'b0, want: 8'hFE});
      vecs.push_back('{acc: 32'd1000,       mul: 32'h7FFFFFFF, sh: 6'd31, zp: 8'h00, relu: 1'b0, want: 8'h7F});
      vecs.push_back('{acc: 32'hFFFFFC18,   mul: 32'h7FFFFFFF, sh: 6'd31, zp: 8'hFB, relu: 1'b0, want: 8'h80});
      vecs.push_back('{acc: 32'h80000000,   mul: 32'd1,        sh: 6'd24, zp: 8'h00, relu: 1'b0, want: 8'h80});
      vecs.push_back('{acc: 32'd5,          mul: 32'd0,        sh: 6'd0,  zp: 8'h07, relu: 1'b0, want: 8'h07});
      vecs.push_back('{acc: 32'd0,          mul: 32'h12345678, sh: 6'd10, zp: 8'hFD, relu: 1'b0, want: 8'hFD});
      vecs.push_back('{acc: 32'd7,          mul: 32'h80000000, sh: 6'd32, zp: 8'h00, relu: 1'b0, want: 8'h04});
      vecs.push_back('{acc: 32'hFFFFFFFB,   mul: 32'h80000000, sh: 6'd32, zp: 8'h00, relu: 1'b0, want: 8'hFD});
      vecs.push_back('{acc: 32'hFFFFFFFF,   mul: 32'hFFFFFFFF, sh: 6'd0,  zp: 8'h64, relu: 1'b0, want: 8'h80});
      vecs.push_back('{acc: 32'd2,          mul: 32'd3,        sh: 6'd0,  zp: 8'h78, relu: 1'b0, want: 8'h7E});
      vecs.push_back('{acc: 32'd2,          mul: 32'd4,        sh: 6'd0,  zp: 8'h78, relu: 1'b0, want: 8'h7F});
      vecs.push_back('{acc: 32'h7FFFFFFF,   mul: 32'hFFFFFFFF, sh: 6'd63, zp: 8'h00, relu: 1'b0, want: 8'h01});
      vecs.push_back('{acc: 32'h80000000,   mul: 32'hFFFFFFFF, sh: 6'd63, zp: 8'h00, relu: 1'b0, want: 8'hFF});
      vecs.push_back('{acc: 32'd200,        mul: 32'd1,        sh: 6'd0,  zp: 8'h80, relu: 1'b0, want: 8'h48});
      vecs.push_back('{acc: 32'hFFFFFF38,   mul: 32'd1,        sh: 6'd0,  zp: 8'h7F, relu: 1'b0, want: 8'hB7});
`ifdef FS_ACCEL_QUANT_RELU_EN
      vecs.push_back('{acc: 32'hFFFFFFFD,   mul: 32'h40000000, sh: 6'd31, zp: 8'h00, relu: 1'b1, want: 8'h00});
      vecs.push_back('{acc: 32'd100,        mul: 32'h40000000, sh: 6'd31, zp: 8'h0A, relu: 1'b1, want: 8'h3C});
      vecs.push_back('{acc: 32'hFFFFFC18,   mul: 32'h7FFFFFFF, sh: 6'd31, zp: 8'hFB, relu: 1'b1, want: 8'hFB});
`endif

      // Asynchronous reset state.
      #3 rst_n = 1'b0;
      #2;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {56'd0, out_data}, 64'd0);
      #17 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i], ac);
         drain();
      end

      // Backpressure: result held 5 cycles, pending operands not accepted early.
      va = vecs[0];
      vb = vecs[1];
      out_ready = 1'b0;
      send(va, ac);
      acc_in      = vb.acc;
      quant_muler = vb.mul;
      quant_shift = vb.sh;
      out_zp      = vb.zp;
      relu        = vb.relu;
      in_valid    = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("hold_wait_valid", {63'd0, ok}, 64'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(vb, ac);
      check("accept_after_hs", 64'(ac), 64'(hs_edge + 1));
      drain();

      // Reset during the 4th multiply cycle aborts with no output.
      send(va, ac);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_out_data", {56'd0, out_data}, 64'd0);
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      send(va, ac);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
